// File: rtl/serial_rx_sipo_pkg.sv
// Shared definitions for the LSB-first serial receiver: state encoding and the
// default frame width.
package serial_rx_sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    STOP  = 2'b10
  } rx_state_t;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/sipo_shreg.sv
// Right-shifting SIPO register with its data-bit counter; count_done marks the
// shift that captures the final data bit of a frame.
module sipo_shreg
  import serial_rx_sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             sin,
  output logic             count_done,
  output logic [WIDTH-1:0] data
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;

  // New bit enters at the MSB so the first bit received ends up at the LSB.
  assign data_next[WIDTH-1] = sin;
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign data_next[gi] = data_reg[gi+1];
    end
  endgenerate

  assign count_done = (count_reg == CW'(WIDTH - 1));
  assign data       = data_reg;

  always_ff @(posedge clock) begin
    if (!clear) begin
      count_reg <= '0;
      data_reg  <= '0;
    end else if (shift_en) begin
      data_reg  <= data_next;
      count_reg <= count_done ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/serial_rx_sipo.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, stop bit, with a
// one-entry valid/ready output and sticky overrun / framing-error flags.
module serial_rx_sipo
  import serial_rx_sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             sin,
  input  logic             sen,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] pout,
  output logic             pvalid,
  output logic             busy,
  output logic             overrun,
  output logic             ferr
);

  rx_state_t        state_reg;
  logic             shift_en;
  logic             count_done;
  logic [WIDTH-1:0] shreg_data;

  assign shift_en = sen && (state_reg == SHIFT);

  sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clock      (clock),
    .clear      (clear),
    .shift_en   (shift_en),
    .sin        (sin),
    .count_done (count_done),
    .data       (shreg_data)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_reg <= IDLE;
      pout      <= '0;
      pvalid    <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      ferr      <= 1'b0;
    end else begin
      // Consumption first; a frame loading on the same edge overrides it below.
      if (pvalid && rd_ready)
        pvalid <= 1'b0;

      if (sen) begin
        unique case (state_reg)
          IDLE: begin
            if (!sin) begin
              state_reg <= SHIFT;
              busy      <= 1'b1;
            end
          end
          SHIFT: begin
            if (count_done)
              state_reg <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            if (sin) begin
              if (!pvalid || rd_ready) begin
                pout   <= shreg_data;
                pvalid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              ferr <= 1'b1;
            end
          end
          default: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_sipo.sv
// Directed bench for serial_rx_sipo: a frame-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_serial_rx_sipo;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         clear = 1'b0;
  logic         sin = 1'b1;
  logic         sen = 1'b0;
  logic         rd_ready = 1'b0;
  logic [W-1:0] pout;
  logic         pvalid, busy, overrun, ferr;

  int n_cmp = 0;
  int n_bad = 0;

  serial_rx_sipo #(.WIDTH(W)) dut (
    .clock    (clock),
    .clear    (clear),
    .sin      (sin),
    .sen      (sen),
    .rd_ready (rd_ready),
    .pout     (pout),
    .pvalid   (pvalid),
    .busy     (busy),
    .overrun  (overrun),
    .ferr     (ferr)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: phase -1 = waiting for start, 0..W-1 = data bits taken, W = awaiting stop.
  int          m_phase = -1;
  int          m_acc = 0;
  int          m_pout = 0;
  bit          m_pvalid = 0, m_overrun = 0, m_ferr = 0, m_init = 0;

  always @(posedge clock) begin
    bit ld;
    ld = 0;
    if (!clear) begin
      m_phase = -1; m_acc = 0; m_pout = 0;
      m_pvalid = 0; m_overrun = 0; m_ferr = 0; m_init = 1;
    end else begin
      if (sen) begin
        if (m_phase < 0) begin
          if (!sin) begin m_phase = 0; m_acc = 0; end
        end else if (m_phase < W) begin
          m_acc = m_acc + (int'(sin) << m_phase);
          m_phase++;
        end else begin
          m_phase = -1;
          if (sin) begin
            if (!m_pvalid || rd_ready) begin m_pout = m_acc; ld = 1; end
            else m_overrun = 1;
          end else begin
            m_ferr = 1;
          end
        end
      end
      if (ld) m_pvalid = 1;
      else if (rd_ready) m_pvalid = 0;
    end
    #1;
    if (m_init) begin
      check("cyc_pout", 32'(pout), 32'(m_pout));
      check("cyc_pvalid", 32'(pvalid), 32'(m_pvalid));
      check("cyc_busy", 32'(busy), 32'(m_phase >= 0));
      check("cyc_overrun", 32'(overrun), 32'(m_overrun));
      check("cyc_ferr", 32'(ferr), 32'(m_ferr));
    end
  end

  logic pv_before_stop;

  task automatic put_bit(input logic b, input bit gap);
    @(negedge clock); sen = 1'b1; sin = b;
    if (gap) begin
      @(negedge clock); sen = 1'b0; sin = ~b;
    end
  endtask

  // Start bit, WIDTH data bits LSB first, then the stop bit; returns at the
  // falling edge after the stop edge with the line idle.
  task automatic send_frame(input logic [W-1:0] d, input logic stop, input bit gap,
                            input logic rdy_at_stop);
    put_bit(1'b0, gap);
    for (int i = 0; i < W; i++) put_bit(d[i], gap);
    @(negedge clock); sen = 1'b1; sin = stop; rd_ready = rdy_at_stop;
    pv_before_stop = pvalid;
    @(negedge clock); sen = 1'b0; sin = 1'b1; rd_ready = 1'b0;
    $display("frame %02h stop=%0b gap=%0b rdy=%0b -> pout=%02h pvalid=%0b overrun=%0b ferr=%0b",
             d, stop, gap, rdy_at_stop, pout, pvalid, overrun, ferr);
  endtask

  task automatic do_reset(input string tag);
    // sen=1 with sin=0 while clear is low: the reset must win over a start bit.
    @(negedge clock); clear = 1'b0; sen = 1'b1; sin = 1'b0; rd_ready = 1'b1;
    @(negedge clock); clear = 1'b1; sen = 1'b0; sin = 1'b1; rd_ready = 1'b0;
    check({tag, "_pout"}, 32'(pout), 32'h0);
    check({tag, "_pvalid"}, 32'(pvalid), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
    check({tag, "_ferr"}, 32'(ferr), 32'h0);
  endtask

  task automatic consume();
    @(negedge clock); rd_ready = 1'b1;
    @(negedge clock); rd_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    do_reset("rst0");

    // Basic frame and one-cycle latency.
    send_frame(8'hA5, 1'b1, 0, 1'b0);
    check("t1_pv_before_stop", 32'(pv_before_stop), 32'h0);
    check("t1_pout", 32'(pout), 32'hA5);
    check("t1_pvalid", 32'(pvalid), 32'h1);
    check("t1_busy", 32'(busy), 32'h0);
    consume();
    check("t1_consumed", 32'(pvalid), 32'h0);
    consume();
    check("t1_idle_ready", 32'(pvalid), 32'h0);

    // Same frame with the strobe toggling.
    send_frame(8'hA5, 1'b1, 1, 1'b0);
    check("t2_pout", 32'(pout), 32'hA5);
    check("t2_pvalid", 32'(pvalid), 32'h1);
    consume();

    do_reset("rst1");
    send_frame(8'h3C, 1'b1, 0, 1'b0);
    send_frame(8'hC3, 1'b1, 0, 1'b0);
    check("t3_pout", 32'(pout), 32'h3C);
    check("t3_pvalid", 32'(pvalid), 32'h1);
    check("t3_overrun", 32'(overrun), 32'h1);

    do_reset("rst2");
    send_frame(8'hFF, 1'b0, 0, 1'b0);
    check("t4_ferr", 32'(ferr), 32'h1);
    check("t4_pvalid", 32'(pvalid), 32'h0);
    check("t4_pout", 32'(pout), 32'h00);

    do_reset("rst3");
    send_frame(8'h11, 1'b1, 0, 1'b0);
    check("t5_first", 32'(pout), 32'h11);
    send_frame(8'h22, 1'b1, 0, 1'b1);
    check("t5_pout", 32'(pout), 32'h22);
    check("t5_pvalid", 32'(pvalid), 32'h1);
    check("t5_overrun", 32'(overrun), 32'h0);

    do_reset("rst4");
    put_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) put_bit(1'b1, 0);
    @(negedge clock); sen = 1'b0;
    check("t6_busy_mid", 32'(busy), 32'h1);
    do_reset("rst5");
    send_frame(8'h5A, 1'b1, 0, 1'b0);
    check("t6_pout", 32'(pout), 32'h5A);
    check("t6_pvalid", 32'(pvalid), 32'h1);
    check("t6_overrun", 32'(overrun), 32'h0);
    check("t6_ferr", 32'(ferr), 32'h0);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
